// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared definitions for the schoolMIPS run/step controller
//
// Purpose: controller state codes and the default step-count width.
// Ports:   none (package).

package sm_pkg;

  // Encoding is visible on the state output: HALT=0, RUN=1, STEP=2.
  // Code 3 is unused and falls back to HALT.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } sm_state_e;

  localparam int SM_CNT_W = 16;

endpackage : sm_pkg

// File: rtl/sm_run_prescaler.sv
// rtl/sm_run_prescaler.sv - free-running rate prescaler for the CPU clock enable
//
// Purpose: counts clk cycles while the controller is active and flags a tick
//          once the count reaches the programmed divider.
// Ports:
//   clk     in            clock
//   rst     in            synchronous active-high reset
//   clr     in            force the count back to 0 on this edge
//   active  in            controller is in RUN or STEP
//   devide  in  [DIV_W]   rate select, tick period is devide+1 cycles
//   tick    out           pulse-due indication for the current cycle

module sm_run_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             active,
  input  logic [DIV_W-1:0] devide,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Greater-or-equal rather than equal: lowering devide below the current
  // count fires on the very next edge instead of wrapping the counter.
  assign tick = active && (cnt_q >= devide);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !active || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sm_run_prescaler

// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/step/halt controller issuing the CPU clock enable
//
// Purpose: sequences the schoolMIPS core by issuing one-cycle cpu_en pulses
//          at a programmable rate in RUN, a counted number of them in STEP,
//          and none in HALT.
// Ports:
//   clk         in            clock
//   rst         in            synchronous active-high reset
//   cmd_run     in            one-cycle request to enter RUN
//   cmd_halt    in            one-cycle request to enter HALT
//   cmd_step    in            one-cycle request to enter STEP
//   step_count  in  [CNT_W]   pulses to issue for a step command
//   devide      in  [DIV_W]   rate select, pulse period devide+1 cycles
//   brk         in            breakpoint level from the core
//   cpu_en      out           registered CPU clock-enable pulse
//   state       out [2]       HALT=0, RUN=1, STEP=2
//   step_left   out [CNT_W]   pulses still to issue in STEP
//   cycle_cnt   out [32]      total pulses issued, wraps

module sm_run_ctrl
  import sm_pkg::*;
#(
  parameter int DIV_W     = 4,
  parameter int CNT_W     = SM_CNT_W,
  parameter int START_RUN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic [CNT_W-1:0] step_count,
  input  logic [DIV_W-1:0] devide,
  input  logic             brk,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_left,
  output logic [31:0]      cycle_cnt
);

  localparam sm_state_e RST_STATE = (START_RUN != 0) ? ST_RUN : ST_HALT;

  sm_state_e        state_q, state_d;
  logic [CNT_W-1:0] step_left_q, step_left_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic             cpu_en_q, cpu_en_d;

  logic halt_req;
  logic active;
  logic tick;
  logic pulse;
  logic start;
  logic pre_clr;

  assign halt_req = cmd_halt | brk;
  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  // A halt sampled on the same edge as a due tick suppresses that pulse.
  assign pulse    = tick & ~halt_req;

  sm_run_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .active (active),
    .devide (devide),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    step_left_d = step_left_q;
    cycle_cnt_d = cycle_cnt_q + {31'd0, pulse};
    cpu_en_d    = pulse;
    start       = 1'b0;

    if (halt_req) begin
      state_d     = ST_HALT;
      step_left_d = '0;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (cmd_run) begin
            state_d = ST_RUN;
            start   = 1'b1;
          end else if (cmd_step && (step_count != '0)) begin
            state_d     = ST_STEP;
            step_left_d = step_count;
            start       = 1'b1;
          end
        end
        ST_RUN: begin
          // cmd_run and cmd_step are both ignored while running.
        end
        ST_STEP: begin
          if (cmd_run) begin
            state_d     = ST_RUN;
            step_left_d = '0;
          end else if (pulse) begin
            step_left_d = step_left_q - CNT_W'(1);
            if (step_left_q == CNT_W'(1)) begin
              state_d = ST_HALT;
            end
          end
        end
        default: begin
          state_d     = ST_HALT;
          step_left_d = '0;
        end
      endcase
    end
  end

  // Restart the rate count on leaving HALT so the first pulse lands exactly
  // devide+1 edges later, and keep it parked at 0 whenever HALT is entered.
  assign pre_clr = start | (state_d == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      step_left_q <= '0;
      cycle_cnt_q <= '0;
      cpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_left_q <= step_left_d;
      cycle_cnt_q <= cycle_cnt_d;
      cpu_en_q    <= cpu_en_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign state     = state_q;
  assign step_left = step_left_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule : sm_run_ctrl
